// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a stability-qualified level filter.
// Produces a clean level, a qualification-busy flag and a saturating bounce count.
module debounce_sync #(
    parameter int STABLE_CYCLES = 16,
    parameter int BOUNCE_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_i,
    output logic                level_o,
    output logic                busy_o,
    output logic [BOUNCE_W-1:0] bounce_cnt_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Bit 0 set only in the two qualifying states, so busy is a single flop bit.
    typedef enum logic [1:0] {
        LOW     = 2'b00,
        TO_HIGH = 2'b01,
        HIGH    = 2'b10,
        TO_LOW  = 2'b11
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               level_nxt;
    logic               bounce_inc;
    logic               sync_q1, sync_q2;

    function automatic logic [BOUNCE_W-1:0] sat_inc(input logic [BOUNCE_W-1:0] v);
        return (&v) ? v : v + BOUNCE_W'(1);
    endfunction

    // Synchronizer stage
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw_i;
            sync_q2 <= sync_q1;
        end
    end

    // State register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOW;
            cnt_q        <= '0;
            level_o      <= 1'b0;
            bounce_cnt_o <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            level_o <= level_nxt;
            if (bounce_inc)
                bounce_cnt_o <= sat_inc(bounce_cnt_o);
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        level_nxt  = level_o;
        bounce_inc = 1'b0;
        unique case (state_q)
            LOW: begin
                cnt_nxt = '0;
                if (sync_q2) begin
                    state_nxt = TO_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            TO_HIGH: begin
                if (!sync_q2) begin
                    state_nxt  = LOW;
                    cnt_nxt    = '0;
                    bounce_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = HIGH;
                    level_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                cnt_nxt = '0;
                if (!sync_q2) begin
                    state_nxt = TO_LOW;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            TO_LOW: begin
                if (sync_q2) begin
                    state_nxt  = HIGH;
                    cnt_nxt    = '0;
                    bounce_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt = LOW;
                    level_nxt = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o = state_q[0];
    end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage for asynchronous, mechanically noisy single-bit inputs such as buttons and switches. It synchronises the raw input into the clock domain and qualifies every level change with a stability counter. It drives a clean, glitch-free level that feeds the edge detector directly. It also reports filter activity and keeps a saturating count of rejected bounces.

## Interface
Parameters:
- STABLE_CYCLES, default 16: consecutive synchronised samples required to accept a new level. Legal range is 2..65535.
- BOUNCE_W, default 8: width of the bounce counter.

Ports:
- clk, input, 1: single clock for all logic.
- reset, input, 1: synchronous, active-high reset.
- raw_i, input, 1: raw asynchronous input. No timing relationship to clk is assumed.
- level_o, output, 1: debounced level, registered. Feeds the edge detector's a_i.
- busy_o, output, 1: high while a candidate transition is being qualified.
- bounce_cnt_o, output, BOUNCE_W: number of aborted candidate transitions. Saturates at all-ones.

## Operation
- Synchronizer: two flops, sync_q1 <= raw_i and sync_q2 <= sync_q1. Both reset to 0. Only sync_q2 (called "sync" below) is used by the rest of the logic.
- Stability counter cnt is $clog2(STABLE_CYCLES) bits wide and resets to 0.
- State machine has four states: LOW, TO_HIGH, HIGH, TO_LOW. Reset state is LOW.
- LOW: if sync=1, go to TO_HIGH with cnt<=1. Otherwise stay, cnt held at 0.
- TO_HIGH:
  - if sync=0, go to LOW, cnt<=0, and increment bounce_cnt_o;
  - else if cnt==STABLE_CYCLES-1, go to HIGH, level_o<=1, cnt<=0;
  - else cnt<=cnt+1.
- HIGH: if sync=0, go to TO_LOW with cnt<=1. Otherwise stay.
- TO_LOW: mirror of TO_HIGH.
  - if sync=1, go to HIGH, cnt<=0, and increment bounce_cnt_o;
  - else if cnt==STABLE_CYCLES-1, go to LOW, level_o<=0, cnt<=0;
  - else cnt<=cnt+1.
- level_o changes only on the TO_HIGH→HIGH and TO_LOW→LOW transitions. It never toggles within a qualification window.
- busy_o is decoded from the state register and is 1 in TO_HIGH and TO_LOW. It is glitch-free.
- bounce_cnt_o increments by 1 per aborted qualification. Once it reaches 2^BOUNCE_W-1 it holds; there is no wrap.

## Timing
- Reset values: level_o=0, busy_o=0, bounce_cnt_o=0, state=LOW, cnt=0, sync_q1=sync_q2=0.
- Reset takes effect at the next clk edge and overrides all other activity, including a mid-qualification state. That qualification is discarded and no bounce is counted.
- After reset deasserts, a raw_i held at 1 is qualified as an ordinary rising transition. The output level is not preset.
- Latency: if raw_i is first captured as 1 at edge k and stays stable, level_o is 1 after edge k+STABLE_CYCLES+1. Falling transitions have the same latency.
- Exactly STABLE_CYCLES consecutive matching sync samples are required; STABLE_CYCLES-1 samples followed by a mismatch produces no output change.
- A mismatch on the final qualifying sample aborts the qualification. That abort counts as a bounce.
- busy_o rises one edge after the first differing sync sample is registered. It falls on the same edge that level_o updates, or on the abort edge.
- Back-to-back transitions: after entering HIGH, a sync=0 sample at the very next edge starts TO_LOW immediately; there is no dead time.
- If reset and an increment of a saturated counter occur together, reset wins.

## Test plan
All scenarios use STABLE_CYCLES=4 and BOUNCE_W=8 unless noted.
- Clean rise: reset, then raw_i=1 from edge 10 onward → level_o=1 after edge 15, busy_o=1 after edges 12..14, bounce_cnt_o=0.
- Bounce reject: raw_i=1 captured at edges 10–11, 0 at edge 12 and after → level_o stays 0, bounce_cnt_o=1, busy_o returns to 0 after edge 14.
- Near miss: sync=1 for 3 samples, then 0 → no level change, bounce_cnt_o=1. Then 4 samples of 1 → level_o=1.
- Clean fall from HIGH: raw_i=0 from edge k → level_o=0 after edge k+5, with symmetric busy_o behaviour.
- Reset mid-qualification: assert reset while in TO_HIGH with cnt=2 → after that edge, all outputs are 0 and state is LOW. No bounce is counted.
- Saturation: with BOUNCE_W=2, generate 5 aborted qualifications → bounce_cnt_o reads 1, 2, 3, 3, 3.
